// File: rtl/caf_pkg.sv
// Shared widths and FSM encoding for the CAF argmax / peak-select path.
package caf_pkg;
  localparam int CAF_FREQ_BINS     = 8;
  localparam int CAF_FREQ_BITS     = 3;
  localparam int ARGMAX_INDEX_BITS = 4;
  localparam int ARGMAX_MAX_BITS   = 4;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_EMIT    = 1'b1
  } caf_state_e;
endpackage

// File: rtl/peak_compare.sv
// Registered compare-and-hold of a (max, index, freq) triple; next-state triple exposed same cycle.
// Strict unsigned greater-than replaces the held value, so ties keep the earlier candidate.
module peak_compare
  import caf_pkg::*;
#(
  parameter int max_bits   = ARGMAX_MAX_BITS,
  parameter int index_bits = ARGMAX_INDEX_BITS,
  parameter int freq_bits  = CAF_FREQ_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  force_load,
  input  logic [max_bits-1:0]   cand_max,
  input  logic [index_bits-1:0] cand_index,
  input  logic [freq_bits-1:0]  cand_freq,
  output logic [max_bits-1:0]   best_max,
  output logic [index_bits-1:0] best_index,
  output logic [freq_bits-1:0]  best_freq,
  output logic [max_bits-1:0]   next_max,
  output logic [index_bits-1:0] next_index,
  output logic [freq_bits-1:0]  next_freq
);
  logic [max_bits-1:0]   best_max_q,   best_max_d;
  logic [index_bits-1:0] best_index_q, best_index_d;
  logic [freq_bits-1:0]  best_freq_q,  best_freq_d;
  logic                  take;

  always_comb begin
    take         = load && (force_load || (cand_max > best_max_q));
    best_max_d   = take ? cand_max   : best_max_q;
    best_index_d = take ? cand_index : best_index_q;
    best_freq_d  = take ? cand_freq  : best_freq_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_max_q   <= '0;
      best_index_q <= '0;
      best_freq_q  <= '0;
    end else begin
      best_max_q   <= best_max_d;
      best_index_q <= best_index_d;
      best_freq_q  <= best_freq_d;
    end
  end

  assign best_max   = best_max_q;
  assign best_index = best_index_q;
  assign best_freq  = best_freq_q;
  assign next_max   = best_max_d;
  assign next_index = best_index_d;
  assign next_freq  = best_freq_d;
endmodule

// File: rtl/caf_peak_select.sv
// Global peak over freq_bins argmax results; result valid from the edge accepting the last bin.
// Upstream ready drops while a result waits; result and ready hold under downstream back-pressure.
module caf_peak_select
  import caf_pkg::*;
#(
  parameter int freq_bins  = CAF_FREQ_BINS,
  parameter int freq_bits  = CAF_FREQ_BITS,
  parameter int index_bits = ARGMAX_INDEX_BITS,
  parameter int max_bits   = ARGMAX_MAX_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m_axis_tvalid,
  input  logic [max_bits-1:0]   in_max,
  input  logic [index_bits-1:0] in_index,
  output logic                  s_axis_tready,
  input  logic [max_bits-1:0]   threshold,
  input  logic                  m_axis_tready,
  output logic                  s_axis_tvalid,
  output logic [max_bits-1:0]   peak_max,
  output logic [index_bits-1:0] peak_index,
  output logic [freq_bits-1:0]  peak_freq,
  output logic                  detect
);
  localparam logic [freq_bits-1:0] LAST_BIN = freq_bits'(freq_bins - 1);

  caf_state_e            state_q, state_d;
  logic                  ready_q, ready_d;
  logic [freq_bits-1:0]  fcnt_q, fcnt_d;
  logic [max_bits-1:0]   peak_max_q, peak_max_d;
  logic [index_bits-1:0] peak_index_q, peak_index_d;
  logic [freq_bits-1:0]  peak_freq_q, peak_freq_d;
  logic                  detect_q, detect_d;
  logic                  in_xfer;

  logic [max_bits-1:0]   best_max, next_max;
  logic [index_bits-1:0] best_index, next_index;
  logic [freq_bits-1:0]  best_freq, next_freq;

  assign in_xfer = m_axis_tvalid && ready_q;

  peak_compare #(
    .max_bits   (max_bits),
    .index_bits (index_bits),
    .freq_bits  (freq_bits)
  ) u_cmp (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (in_xfer),
    .force_load (fcnt_q == '0),
    .cand_max   (in_max),
    .cand_index (in_index),
    .cand_freq  (fcnt_q),
    .best_max   (best_max),
    .best_index (best_index),
    .best_freq  (best_freq),
    .next_max   (next_max),
    .next_index (next_index),
    .next_freq  (next_freq)
  );

  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    peak_max_d   = peak_max_q;
    peak_index_d = peak_index_q;
    peak_freq_d  = peak_freq_q;
    detect_d     = detect_q;
    case (state_q)
      ST_COLLECT: begin
        if (in_xfer) begin
          if (fcnt_q == LAST_BIN) begin
            // Final bin: capture the post-compare triple in the same edge.
            fcnt_d       = '0;
            state_d      = ST_EMIT;
            peak_max_d   = next_max;
            peak_index_d = next_index;
            peak_freq_d  = next_freq;
            detect_d     = next_max > threshold;
          end else begin
            fcnt_d = fcnt_q + freq_bits'(1);
          end
        end
      end
      ST_EMIT: begin
        if (m_axis_tready) state_d = ST_COLLECT;
      end
      default: state_d = ST_COLLECT;
    endcase
    ready_d = (state_d == ST_COLLECT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_COLLECT;
      ready_q      <= 1'b0;
      fcnt_q       <= '0;
      peak_max_q   <= '0;
      peak_index_q <= '0;
      peak_freq_q  <= '0;
      detect_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      fcnt_q       <= fcnt_d;
      peak_max_q   <= peak_max_d;
      peak_index_q <= peak_index_d;
      peak_freq_q  <= peak_freq_d;
      detect_q     <= detect_d;
    end
  end

  // Held triple is only observed through next_*; kept visible for multi-channel reuse.
  logic unused_best;
  assign unused_best = ^{best_max, best_index, best_freq};

  assign s_axis_tready = ready_q;
  assign s_axis_tvalid = (state_q == ST_EMIT);
  assign peak_max      = peak_max_q;
  assign peak_index    = peak_index_q;
  assign peak_freq     = peak_freq_q;
  assign detect        = detect_q;
endmodule

// File: tb/tb_caf_peak_select.sv
// Directed and randomized frames for caf_peak_select against a frame-level reference model.
module tb_caf_peak_select;
  localparam int FB = 8;
  localparam int FQ = 3;
  localparam int IB = 4;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m_axis_tvalid = 1'b0;
  logic [MB-1:0] in_max = '0;
  logic [IB-1:0] in_index = '0;
  logic          s_axis_tready;
  logic [MB-1:0] threshold = '0;
  logic          m_axis_tready = 1'b0;
  logic          s_axis_tvalid;
  logic [MB-1:0] peak_max;
  logic [IB-1:0] peak_index;
  logic [FQ-1:0] peak_freq;
  logic          detect;

  caf_peak_select #(
    .freq_bins  (FB),
    .freq_bits  (FQ),
    .index_bits (IB),
    .max_bits   (MB)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .m_axis_tvalid (m_axis_tvalid),
    .in_max        (in_max),
    .in_index      (in_index),
    .s_axis_tready (s_axis_tready),
    .threshold     (threshold),
    .m_axis_tready (m_axis_tready),
    .s_axis_tvalid (s_axis_tvalid),
    .peak_max      (peak_max),
    .peak_index    (peak_index),
    .peak_freq     (peak_freq),
    .detect        (detect)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [MB-1:0] fmax [FB];
  logic [IB-1:0] fidx [FB];
  logic [MB-1:0] e_max;
  logic [IB-1:0] e_idx;
  logic [FQ-1:0] e_freq;
  logic          e_det;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: largest magnitude of the frame, first bin holding it wins.
  task automatic model(input logic [MB-1:0] thr);
    int m = 0;
    int p = 0;
    for (int i = 0; i < FB; i++) if (int'(fmax[i]) > m) m = int'(fmax[i]);
    for (int i = FB - 1; i >= 0; i--) if (int'(fmax[i]) == m) p = i;
    e_max  = MB'(m);
    e_idx  = fidx[p];
    e_freq = FQ'(p);
    e_det  = (m > int'(thr));
  endtask

  task automatic push(input logic [MB-1:0] mx, input logic [IB-1:0] ix, input int gap);
    int w = 0;
    for (int g = 0; g < gap; g++) @(negedge clk);
    @(negedge clk);
    m_axis_tvalid = 1'b1;
    in_max        = mx;
    in_index      = ix;
    while (!s_axis_tready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready", 32'(s_axis_tready), 32'd1);
    chk("in_tvalid_low", 32'(s_axis_tvalid), 32'd0);
    @(posedge clk);
    #1;
    m_axis_tvalid = 1'b0;
    in_max        = MB'($urandom);
    in_index      = IB'($urandom);
  endtask

  task automatic check_result(input string tag);
    chk({tag, "_tvalid"}, 32'(s_axis_tvalid), 32'd1);
    chk({tag, "_ready"}, 32'(s_axis_tready), 32'd0);
    chk({tag, "_max"}, 32'(peak_max), 32'(e_max));
    chk({tag, "_index"}, 32'(peak_index), 32'(e_idx));
    chk({tag, "_freq"}, 32'(peak_freq), 32'(e_freq));
    chk({tag, "_detect"}, 32'(detect), 32'(e_det));
  endtask

  // Result must be visible at the first negedge after the last accept.
  task automatic pop(input string tag);
    @(negedge clk);
    check_result(tag);
    m_axis_tready = 1'b1;
    @(posedge clk);
    #1;
    m_axis_tready = 1'b0;
    @(negedge clk);
    chk({tag, "_ready_after"}, 32'(s_axis_tready), 32'd1);
    chk({tag, "_tvalid_after"}, 32'(s_axis_tvalid), 32'd0);
    chk({tag, "_hold_max"}, 32'(peak_max), 32'(e_max));
  endtask

  task automatic send_frame(input logic [MB-1:0] thr, input int gapmax);
    threshold = thr;
    for (int i = 0; i < FB; i++)
      push(fmax[i], fidx[i], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
    model(thr);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_ready", 32'(s_axis_tready), 32'd0);
    chk("rst_tvalid", 32'(s_axis_tvalid), 32'd0);
    chk("rst_max", 32'(peak_max), 32'd0);
    chk("rst_detect", 32'(detect), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_ready_low", 32'(s_axis_tready), 32'd0);
    @(negedge clk);
    chk("rel_ready_high", 32'(s_axis_tready), 32'd1);

    // Basic frame
    for (int i = 0; i < FB; i++) fidx[i] = IB'(i + 5);
    fmax[0] = 4'd1; fmax[1] = 4'd2; fmax[2] = 4'd3; fmax[3] = 4'd9;
    fmax[4] = 4'd4; fmax[5] = 4'd5; fmax[6] = 4'd6; fmax[7] = 4'd7;
    send_frame(4'd8, 0);
    pop("basic");

    // All ties, strict detect
    for (int i = 0; i < FB; i++) begin
      fmax[i] = 4'd6;
      fidx[i] = IB'(i + 2);
    end
    send_frame(4'd6, 0);
    pop("ties");

    // Asynchronous reset after 4 accepts
    for (int i = 0; i < 4; i++) push(4'd15, 4'd9, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", 32'(s_axis_tready), 32'd0);
    chk("arst_tvalid", 32'(s_axis_tvalid), 32'd0);
    chk("arst_max", 32'(peak_max), 32'd0);
    chk("arst_index", 32'(peak_index), 32'd0);
    chk("arst_freq", 32'(peak_freq), 32'd0);
    chk("arst_detect", 32'(detect), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < FB; i++) begin
      fmax[i] = MB'(i % 3 + 1);
      fidx[i] = IB'(12 - i);
    end
    send_frame(4'd2, 0);
    pop("post_rst");

    // Back-pressure with upstream valid toggling
    for (int i = 0; i < FB; i++) begin
      fmax[i] = MB'((i * 7) % 11);
      fidx[i] = IB'(i * 3);
    end
    send_frame(4'd12, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      m_axis_tvalid = k[0];
      in_max        = 4'd15;
      check_result("bp");
    end
    m_axis_tvalid = 1'b0;
    pop("bp_rel");

    // Max at the last bin, then an all-zero frame
    for (int i = 0; i < FB; i++) begin
      fmax[i] = MB'(i);
      fidx[i] = IB'(15 - i);
    end
    fmax[FB-1] = 4'd15;
    send_frame(4'd3, 0);
    pop("lastbin");
    for (int i = 0; i < FB; i++) begin
      fmax[i] = '0;
      fidx[i] = IB'(i + 1);
    end
    send_frame(4'd0, 0);
    pop("zeros");

    // Random frames with upstream gaps
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < FB; i++) begin
        fmax[i] = (f % 2 == 0) ? MB'($urandom_range(0, 15)) : MB'($urandom_range(0, 3));
        fidx[i] = IB'($urandom);
      end
      send_frame(MB'($urandom), 3);
      pop("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
